// File: rtl/rx_status_fifo_pkg.sv
// Shared DUART definitions: default character/status widths, status bit indices
// and the explicit pointer-wrap helper used by the receive FIFO.
package rx_status_fifo_pkg;

   localparam int DUART_DATA_W = 8;
   localparam int DUART_STAT_W = 3;

   // Bit positions inside the per-character status word.
   localparam int STAT_PE = 0;
   localparam int STAT_FE = 1;
   localparam int STAT_RB = 2;

   // Pointers run 0..depth-1; depth need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rx_status_fifo.sv
// UART receive FIFO with per-character status, a one-entry overflow holding
// register, sticky overrun flag and edge-detected CPU read strobe.
module rx_status_fifo
   import rx_status_fifo_pkg::*;
#(
   parameter int DATA_W = DUART_DATA_W,
   parameter int STAT_W = DUART_STAT_W,
   parameter int DEPTH  = 3,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              RESETN,
   input  logic              wr,
   input  logic [DATA_W-1:0] d_in,
   input  logic [STAT_W-1:0] stat_in,
   input  logic              rd,
   input  logic              flush,
   input  logic              clr_over,
   output logic [DATA_W-1:0] d_out,
   output logic [STAT_W-1:0] stat_out,
   output logic [CNT_W-1:0]  count,
   output logic              RxRDY,
   output logic              FFULL,
   output logic              hold_valid,
   output logic              OVER
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] dmem_q [DEPTH];
   logic [STAT_W-1:0] smem_q [DEPTH];

   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [DATA_W-1:0] hdata_q, hdata_d;
   logic [STAT_W-1:0] hstat_q, hstat_d;
   logic              hv_q, hv_d;
   logic              over_q, over_d;
   logic              rd_q;

   logic              empty, full, pop_req, eff_pop, over_set;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [STAT_W-1:0] mem_wstat;
   logic [PTR_W-1:0]  rptr_inc, wptr_inc;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign pop_req  = rd & ~rd_q;
   assign eff_pop  = pop_req & ~empty & ~flush;
   assign rptr_inc = PTR_W'(wrap_inc(int'(rptr_q), DEPTH));
   assign wptr_inc = PTR_W'(wrap_inc(int'(wptr_q), DEPTH));

   always_comb begin
      rptr_d    = rptr_q;
      wptr_d    = wptr_q;
      count_d   = count_q;
      dout_d    = dout_q;
      hdata_d   = hdata_q;
      hstat_d   = hstat_q;
      hv_d      = hv_q;
      over_set  = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = d_in;
      mem_wstat = stat_in;

      if (flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
         hv_d    = 1'b0;
      end else if (eff_pop) begin
         dout_d = dmem_q[rptr_q];
         rptr_d = rptr_inc;
         if (hv_q) begin
            // Held character drops into the slot just freed; FIFO stays full.
            mem_we    = 1'b1;
            mem_wdata = hdata_q;
            mem_wstat = hstat_q;
            wptr_d    = wptr_inc;
            hv_d      = wr;
            if (wr) begin
               hdata_d = d_in;
               hstat_d = stat_in;
            end
         end else if (wr) begin
            mem_we = 1'b1;
            wptr_d = wptr_inc;
         end else begin
            count_d = count_q - CNT_W'(1);
         end
      end else if (wr) begin
         if (!full) begin
            mem_we  = 1'b1;
            wptr_d  = wptr_inc;
            count_d = count_q + CNT_W'(1);
         end else begin
            hdata_d  = d_in;
            hstat_d  = stat_in;
            hv_d     = 1'b1;
            over_set = hv_q;
         end
      end

      // A fresh overrun beats a same-cycle clear.
      if (over_set)
         over_d = 1'b1;
      else if (clr_over)
         over_d = 1'b0;
      else
         over_d = over_q;
   end

   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         hdata_q <= '0;
         hstat_q <= '0;
         hv_q    <= 1'b0;
         over_q  <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         hdata_q <= hdata_d;
         hstat_q <= hstat_d;
         hv_q    <= hv_d;
         over_q  <= over_d;
         rd_q    <= rd;
      end
   end

   // Storage is left unreset; count/pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         dmem_q[wptr_q] <= mem_wdata;
         smem_q[wptr_q] <= mem_wstat;
      end
   end

   assign d_out      = dout_q;
   assign stat_out   = empty ? '0 : smem_q[rptr_q];
   assign count      = count_q;
   assign RxRDY      = ~empty;
   assign FFULL      = full;
   assign hold_valid = hv_q;
   assign OVER       = over_q;

endmodule

// File: tb/tb_rx_status_fifo.sv
// Bench for rx_status_fifo: two instances (DEPTH 3 and 5) share stimulus and
// are checked every cycle against a list-based reference model.
module tb_rx_status_fifo;

   logic       clk = 1'b0;
   logic       RESETN;
   logic       wr, rd, flush, clr_over;
   logic [7:0] d_in;
   logic [2:0] stat_in;

   logic [7:0] d_out3, d_out5;
   logic [2:0] stat3, stat5;
   logic [1:0] count3;
   logic [2:0] count5;
   logic       rx3, rx5, ff3, ff5, hv3, hv5, ov3, ov5;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rx_status_fifo #(.DATA_W(8), .STAT_W(3), .DEPTH(3)) u3 (
      .clk(clk), .RESETN(RESETN), .wr(wr), .d_in(d_in), .stat_in(stat_in),
      .rd(rd), .flush(flush), .clr_over(clr_over),
      .d_out(d_out3), .stat_out(stat3), .count(count3), .RxRDY(rx3),
      .FFULL(ff3), .hold_valid(hv3), .OVER(ov3));

   rx_status_fifo #(.DATA_W(8), .STAT_W(3), .DEPTH(5)) u5 (
      .clk(clk), .RESETN(RESETN), .wr(wr), .d_in(d_in), .stat_in(stat_in),
      .rd(rd), .flush(flush), .clr_over(clr_over),
      .d_out(d_out5), .stat_out(stat5), .count(count5), .RxRDY(rx5),
      .FFULL(ff5), .hold_valid(hv5), .OVER(ov5));

   // Reference model: an ordered list of {stat,data}, shifted on every pop.
   logic [10:0] ment [2][8];
   int          mn   [2];
   logic [10:0] mhold[2];
   bit          mhv  [2];
   bit          mov  [2];
   logic [7:0]  mdout[2];
   bit          mrdp [2];

   function automatic void mreset();
      for (int k = 0; k < 2; k++) begin
         mn[k] = 0; mhv[k] = 0; mov[k] = 0; mdout[k] = '0; mrdp[k] = 0;
      end
   endfunction

   function automatic void mstep(input int k);
      int depth = (k == 0) ? 3 : 5;
      bit pop   = rd && !mrdp[k];
      bit ovr   = 0;
      mrdp[k] = rd;
      if (flush) begin
         mn[k]  = 0;
         mhv[k] = 0;
      end else begin
         if (pop && mn[k] > 0) begin
            mdout[k] = ment[k][0][7:0];
            for (int i = 0; i < 7; i++) ment[k][i] = ment[k][i+1];
            mn[k]--;
            if (mhv[k]) begin
               ment[k][mn[k]] = mhold[k];
               mn[k]++;
               mhv[k] = 0;
            end
         end
         if (wr) begin
            if (mn[k] < depth) begin
               ment[k][mn[k]] = {stat_in, d_in};
               mn[k]++;
            end else begin
               if (mhv[k]) ovr = 1;
               mhold[k] = {stat_in, d_in};
               mhv[k]   = 1;
            end
         end
      end
      if (ovr) mov[k] = 1;
      else if (clr_over) mov[k] = 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] dq; logic [2:0] sq; int cq; logic rq, fq, hq, oq;
         int depth = (k == 0) ? 3 : 5;
         string sfx = (k == 0) ? "_d3" : "_d5";
         if (k == 0) begin
            dq = d_out3; sq = stat3; cq = int'(count3); rq = rx3; fq = ff3; hq = hv3; oq = ov3;
         end else begin
            dq = d_out5; sq = stat5; cq = int'(count5); rq = rx5; fq = ff5; hq = hv5; oq = ov5;
         end
         chk({tag, sfx, ".d_out"},      32'(dq), 32'(mdout[k]));
         chk({tag, sfx, ".count"},      32'(cq), 32'(mn[k]));
         chk({tag, sfx, ".stat_out"},   32'(sq), (mn[k] > 0) ? 32'(ment[k][0][10:8]) : 32'h0);
         chk({tag, sfx, ".RxRDY"},      32'(rq), 32'(mn[k] > 0));
         chk({tag, sfx, ".FFULL"},      32'(fq), 32'(mn[k] == depth));
         chk({tag, sfx, ".hold_valid"}, 32'(hq), 32'(mhv[k]));
         chk({tag, sfx, ".OVER"},       32'(oq), 32'(mov[k]));
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      mstep(0);
      mstep(1);
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      wr = 0; rd = 0; flush = 0; clr_over = 0;
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] s, input string tag);
      wr = 1; d_in = d; stat_in = s;
      step(tag);
      wr = 0;
   endtask

   task automatic pop_pulse(input string tag);
      rd = 1;
      step(tag);
      rd = 0;
      step({tag, "_rel"});
   endtask

   logic [7:0] prev;

   initial begin
      idle();
      d_in = '0; stat_in = '0;
      RESETN = 0;
      mreset();
      #3;
      check_all("reset");
      chk("reset.d_out", 32'(d_out3), 32'h0);
      chk("reset.count", 32'(count3), 32'h0);
      @(posedge clk); #1;
      RESETN = 1;

      // In-order delivery with status.
      push(8'h41, 3'b001, "p41");
      push(8'h42, 3'b010, "p42");
      push(8'h43, 3'b100, "p43");
      chk("seq.count3", 32'(count3), 32'd3);
      chk("seq.stat_head", 32'(stat3), 32'b001);
      pop_pulse("pop1");
      chk("seq.d_out1", 32'(d_out3), 32'h41);
      chk("seq.count2", 32'(count3), 32'd2);
      pop_pulse("pop2");
      chk("seq.d_out2", 32'(d_out3), 32'h42);
      pop_pulse("pop3");
      chk("seq.d_out3", 32'(d_out3), 32'h43);
      chk("seq.count0", 32'(count3), 32'd0);
      chk("seq.rxrdy", 32'(rx3), 32'd0);
      chk("seq.stat_empty", 32'(stat3), 32'd0);

      // Held rd pops exactly once.
      push(8'h10, 3'b000, "h1");
      push(8'h11, 3'b011, "h2");
      rd = 1;
      for (int i = 0; i < 10; i++) step("rdheld");
      chk("held.count", 32'(count3), 32'd1);
      chk("held.d_out", 32'(d_out3), 32'h10);
      rd = 0;
      step("rdrel");
      pop_pulse("drain");

      // Full FIFO, holding register and overrun.
      push(8'hA1, 3'b000, "f1");
      push(8'hA2, 3'b001, "f2");
      push(8'hA3, 3'b010, "f3");
      push(8'h55, 3'b111, "f55");
      chk("hold.hv", 32'(hv3), 32'd1);
      chk("hold.full", 32'(ff3), 32'd1);
      chk("hold.over", 32'(ov3), 32'd0);
      push(8'h66, 3'b110, "f66");
      chk("ovr.over", 32'(ov3), 32'd1);
      rd = 1;
      step("ovr_pop");
      rd = 0;
      chk("ovr.d_out", 32'(d_out3), 32'hA1);
      chk("ovr.count", 32'(count3), 32'd3);
      chk("ovr.hv", 32'(hv3), 32'd0);
      step("ovr_rel");

      // Flush keeps OVER and d_out; clr_over then clears OVER.
      push(8'h77, 3'b000, "f77");
      chk("pre_flush.hv", 32'(hv3), 32'd1);
      flush = 1; wr = 1; rd = 1; d_in = 8'h99;
      step("flush");
      idle();
      chk("flush.count", 32'(count3), 32'd0);
      chk("flush.hv", 32'(hv3), 32'd0);
      chk("flush.over", 32'(ov3), 32'd1);
      chk("flush.d_out", 32'(d_out3), 32'hA1);
      step("flush_gap");
      clr_over = 1;
      step("clr");
      clr_over = 0;
      chk("clr.over", 32'(ov3), 32'd0);

      // Overrun in the same cycle as clr_over wins.
      for (int i = 0; i < 4; i++) push(8'(8'hB0 + i), 3'(i), "fill");
      wr = 1; d_in = 8'hBF; clr_over = 1;
      step("ovr_vs_clr");
      idle();
      chk("ovr_vs_clr.over", 32'(ov3), 32'd1);
      flush = 1; clr_over = 1;
      step("flush2");
      idle();

      // Simultaneous wr+rd at count 1, many times to wrap both pointers.
      push(8'hC0, 3'b001, "w0");
      prev = 8'hC0;
      for (int i = 1; i <= 12; i++) begin
         wr = 1; rd = 1; d_in = 8'(8'hC0 + i); stat_in = 3'(i);
         step("wrrd");
         chk("wrrd.count3", 32'(count3), 32'd1);
         chk("wrrd.count5", 32'(count5), 32'd1);
         chk("wrrd.d_out5", 32'(d_out5), 32'(prev));
         prev = d_in;
         idle();
         step("wrrd_gap");
      end
      pop_pulse("wrrd_drain");

      // Asynchronous reset in the middle of a push stream.
      for (int i = 0; i < 3; i++) push(8'(8'hD0 + i), 3'(i), "stream");
      wr = 1; d_in = 8'hDD;
      #2;
      RESETN = 0;
      #1;
      mreset();
      check_all("async_rst");
      chk("async_rst.count5", 32'(count5), 32'd0);
      chk("async_rst.d_out3", 32'(d_out3), 32'd0);
      idle();
      @(posedge clk); #1;
      check_all("rst_hold");
      RESETN = 1;
      step("post_rst");

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         wr       = ($urandom_range(0, 1) == 1);
         rd       = ($urandom_range(0, 2) == 0);
         flush    = ($urandom_range(0, 39) == 0);
         clr_over = ($urandom_range(0, 14) == 0);
         d_in     = 8'($urandom);
         stat_in  = 3'($urandom);
         step("rand");
      end
      idle();
      step("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
